mem_access_unit: RTL

Memory-stage load/store unit of the RV32I pipeline. It consumes the MEM-stage control, address and store data held in the EX/MEM pipeline register, and runs one request/acknowledge transaction per load or store on the data-memory bus. It aligns store data and byte enables, extracts and sign/zero-extends load data for the MEM/WB register, and stalls the pipeline while a transaction is in flight.

---
 rtl/riscv_mem_pkg.sv | 20 ++
 rtl/mem_access_unit_if.sv | 12 +
 rtl/mem_load_align.sv | 17 +
 rtl/mem_access_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: CRT_MEM field positions, funct3 encodings and FSM states for the memory stage.
package riscv_mem_pkg;
    localparam int CRT_MEM_READ  = 0;
    localparam int CRT_MEM_WRITE = 1;
    localparam int CRT_F3_LO     = 2;
    localparam int CRT_F3_HI     = 4;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_e;
    function automatic logic f3_legal(logic is_load, logic [2:0] f3);
        return is_load ? (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU})
                       : (f3 inside {F3_SB, F3_SH, F3_SW});
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/acknowledge data-memory bus between the load/store unit and memory.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    modport master(output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, input dmem_ack, dmem_rdata);
    modport slave(input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half/word lane out of a read word and sign/zero-extends it.
module mem_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] lane;
    assign lane = rdata >> {off, 3'b000};
    always_comb
        data = funct3 == F3_LB  ? {{24{lane[7]}}, lane[7:0]}   :
               funct3 == F3_LH  ? {{16{lane[15]}}, lane[15:0]} :
               funct3 == F3_LBU ? {24'b0, lane[7:0]}           :
               funct3 == F3_LHU ? {16'b0, lane[15:0]}          : lane;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I MEM-stage load/store unit running one req/ack bus transaction per access.
// Defining MEM_ACCESS_TIMEOUT_EN adds a REQ watchdog that faults after TIMEOUT_CYCLES without ack.
module mem_access_unit
    import riscv_mem_pkg::*;
`ifdef MEM_ACCESS_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4:0]                crt_mem_in,
    input  logic [31:0]               alu_result_in,
    input  logic [31:0]               dato_b_in,
    mem_access_unit_if.master         bus,
    output logic [31:0]               load_data_out,
    output logic                      stall_out,
    output logic                      fault_out
);
    mem_state_e  state;
    logic        mem_rd, mem_wr, op, aligned, ok;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata, ld_fmt;
`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`endif
    assign mem_rd = crt_mem_in[CRT_MEM_READ];
    assign mem_wr = crt_mem_in[CRT_MEM_WRITE];
    assign f3     = crt_mem_in[CRT_F3_HI:CRT_F3_LO];
    assign off    = alu_result_in[1:0];
    assign op     = mem_rd | mem_wr;
    // funct3[1:0] encodes the access size for both loads and stores
    always_comb begin
        aligned = f3[1:0] == 2'b00 ? 1'b1 : f3[1:0] == 2'b01 ? ~off[0] : off == 2'b00;
        ok      = f3_legal(mem_rd, f3) & aligned;
        be      = f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
        wdata   = f3[1:0] == 2'b00 ? {4{dato_b_in[7:0]}} :
                  f3[1:0] == 2'b01 ? {2{dato_b_in[15:0]}} : dato_b_in;
    end
    // EX/MEM inputs are frozen by stall_out, so they still describe the access while in REQ
    mem_load_align u_align (
        .rdata  (bus.dmem_rdata),
        .off    (off),
        .funct3 (f3),
        .data   (ld_fmt)
    );
    assign stall_out = rst & ((state == REQ) | ((state == IDLE) & op));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bus.dmem_req  <= 1'b0;
            bus.dmem_we   <= 1'b0;
            bus.dmem_addr <= '0;
            bus.dmem_be   <= '0;
            bus.dmem_wdata <= '0;
            load_data_out <= '0;
            fault_out     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (op) begin
                    if (ok) begin
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= ~mem_rd;
                        bus.dmem_addr  <= {alu_result_in[31:2], 2'b00};
                        bus.dmem_be    <= be;
                        bus.dmem_wdata <= wdata;
                        state          <= REQ;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        cnt            <= '0;
`endif
                    end else begin
                        fault_out <= 1'b1;
                        state     <= DONE;
                    end
                end
                REQ: if (bus.dmem_ack) begin
                    bus.dmem_req <= 1'b0;
                    if (mem_rd) load_data_out <= ld_fmt;
                    state <= DONE;
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    bus.dmem_req <= 1'b0;
                    fault_out    <= 1'b1;
                    state        <= DONE;
                end else cnt <= cnt + 1'b1;
`endif
                DONE: begin
                    fault_out <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
